// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe divider, zero-based
// active-area coordinates, pipelined sync/blank outputs and a sticky vblank flag.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        irq_ack,
  output logic        pix_tick,
  output logic        pix_clk,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n,
  output logic        frame_start,
  output logic        vblank_flag
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [15:0] H_TOTAL  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [15:0] H_ACT16  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT16  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Delay-line word is {hsync, vsync, active}; idle is the deasserted level.
  localparam logic [2:0] DLY_IDLE = {~HS_POL, ~VS_POL, 1'b0};

  logic [DW-1:0] r_div;
  logic [15:0]   r_h;
  logic [15:0]   r_v;
  logic [15:0]   r_pixX;
  logic [15:0]   r_pixY;
  logic          r_active;
  logic          r_frameStart;
  logic          r_vblankFlag;
  logic [2:0]    r_dly [PIPE_DELAY+1];

  logic          w_tick;
  logic          w_hWrap;
  logic [15:0]   w_hNext;
  logic [15:0]   w_vNext;
  logic          w_activeNext;
  logic          w_hsyncNext;
  logic          w_vsyncNext;

  assign w_tick   = enable && (r_div == DIV_LAST);
  assign pix_tick = w_tick;
  assign pix_clk  = (r_div >= DIV_HALF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
    end else if (enable) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  // Raster position after the coming tick; registered outputs load from it
  // so they line up with the counters in the same cycle.
  always_comb begin
    w_hWrap = (r_h == H_TOTAL - 16'd1);
    w_hNext = w_hWrap ? '0 : r_h + 16'd1;
    w_vNext = r_v;
    if (w_hWrap) begin
      w_vNext = (r_v == V_TOTAL - 16'd1) ? '0 : r_v + 16'd1;
    end
    w_activeNext = (w_hNext < H_ACT16) && (w_vNext < V_ACT16);
    w_hsyncNext  = ((w_hNext >= HS_START) && (w_hNext <= HS_END)) ? HS_POL : ~HS_POL;
    w_vsyncNext  = ((w_vNext >= VS_START) && (w_vNext <= VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h      <= '0;
      r_v      <= '0;
      r_pixX   <= '0;
      r_pixY   <= '0;
      r_active <= 1'b0;
    end else if (w_tick) begin
      r_h      <= w_hNext;
      r_v      <= w_vNext;
      r_pixX   <= w_activeNext ? w_hNext : '0;
      r_pixY   <= w_activeNext ? w_vNext : '0;
      r_active <= w_activeNext;
    end
  end

  // Stage 0 holds the registered raw levels; stage PIPE_DELAY drives the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_DELAY; i++) begin
        r_dly[i] <= DLY_IDLE;
      end
    end else if (w_tick) begin
      r_dly[0] <= {w_hsyncNext, w_vsyncNext, w_activeNext};
      for (int i = 1; i <= PIPE_DELAY; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  // A vblank set on the same cycle as an acknowledge takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frameStart <= 1'b0;
      r_vblankFlag <= 1'b0;
    end else begin
      r_frameStart <= w_tick && (w_hNext == '0) && (w_vNext == '0);
      if (w_tick && (w_vNext == V_ACT16) && (w_hNext == '0)) begin
        r_vblankFlag <= 1'b1;
      end else if (irq_ack) begin
        r_vblankFlag <= 1'b0;
      end
    end
  end

  assign pix_x       = r_pixX;
  assign pix_y       = r_pixY;
  assign active      = r_active;
  assign hsync       = r_dly[PIPE_DELAY][2];
  assign vsync       = r_dly[PIPE_DELAY][1];
  assign blank_n     = r_dly[PIPE_DELAY][0];
  assign sync_n      = ~((hsync == HS_POL) || (vsync == VS_POL));
  assign frame_start = r_frameStart;
  assign vblank_flag = r_vblankFlag;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: a tick-count model derives the expected
// raster position, delayed syncs and vblank flag from plain arithmetic.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 6, VF = 1, VSW = 2, VB = 1;
  localparam int CD = 3, PD = 2;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        irq_ack = 1'b0;
  logic        pix_tick, pix_clk, active, hsync, vsync, blank_n, sync_n;
  logic        frame_start, vblank_flag;
  logic [15:0] pix_x, pix_y;

  int nChecks = 0;
  int nFails  = 0;

  int mE = 0;
  int mK = 0;
  bit mLastTick = 1'b0;
  bit mFlag = 1'b0;
  bit mEnNow = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .CLK_DIV(CD), .PIPE_DELAY(PD), .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .irq_ack(irq_ack),
    .pix_tick(pix_tick), .pix_clk(pix_clk), .pix_x(pix_x), .pix_y(pix_y),
    .active(active), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .sync_n(sync_n), .frame_start(frame_start), .vblank_flag(vblank_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit rawH(input int p);
    int h = p % HT;
    return (h >= HA + HF && h < HA + HF + HSW) ? HP : !HP;
  endfunction

  function automatic bit rawV(input int p);
    int v = p / HT;
    return (v >= VA + VF && v < VA + VF + VSW) ? VP : !VP;
  endfunction

  function automatic bit rawA(input int p);
    return (p % HT < HA) && (p / HT < VA);
  endfunction

  // Position is simply ticks-since-reset modulo the frame; the delayed pins
  // show the raw levels from PD ticks ago, idle before any tick was seen.
  task automatic checkAll();
    int div = mE % CD;
    int p   = mK % FR;
    int j   = mK - PD;
    bit act = (mK > 0) && rawA(p);
    bit hs  = (j >= 1) ? rawH(j % FR) : !HP;
    bit vs  = (j >= 1) ? rawV(j % FR) : !VP;
    bit bl  = (j >= 1) ? rawA(j % FR) : 1'b0;
    checkOutput("pix_tick",    32'(pix_tick),    32'(mEnNow && div == CD - 1));
    checkOutput("pix_clk",     32'(pix_clk),     32'(div >= CD / 2));
    checkOutput("active",      32'(active),      32'(act));
    checkOutput("pix_x",       32'(pix_x),       act ? 32'(p % HT) : 32'd0);
    checkOutput("pix_y",       32'(pix_y),       act ? 32'(p / HT) : 32'd0);
    checkOutput("hsync",       32'(hsync),       32'(hs));
    checkOutput("vsync",       32'(vsync),       32'(vs));
    checkOutput("blank_n",     32'(blank_n),     32'(bl));
    checkOutput("sync_n",      32'(sync_n),      32'(!(hs == HP || vs == VP)));
    checkOutput("frame_start", 32'(frame_start), 32'(mLastTick && p == 0));
    checkOutput("vblank_flag", 32'(vblank_flag), 32'(mFlag));
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit ack);
    reset   = rst;
    enable  = en;
    irq_ack = ack;
    @(posedge clk);
    if (rst) begin
      mE = 0; mK = 0; mLastTick = 1'b0; mFlag = 1'b0;
    end else begin
      mLastTick = 1'b0;
      if (en) begin
        if (mE % CD == CD - 1) begin
          mLastTick = 1'b1;
          mK++;
        end
        mE++;
      end
      if (mLastTick && (mK % FR == VA * HT)) mFlag = 1'b1;
      else if (ack) mFlag = 1'b0;
    end
    mEnNow = en;
    @(negedge clk);
    checkOutput("reset_seen", 32'(reset), 32'(rst));
    checkAll();
  endtask

  // Acknowledge sometimes lands exactly on the vblank-setting edge.
  function automatic bit pickAck(input bit en);
    bit willSet = en && (mE % CD == CD - 1) && ((mK + 1) % FR == VA * HT);
    return (willSet && $urandom_range(0, 1) == 1) || ($urandom_range(0, 15) == 0);
  endfunction

  initial begin
    bit en;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b1, pickAck(1'b1));
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      applyStimulus($urandom_range(0, 499) == 0, en, pickAck(en));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
